// File: rtl/scoreboard_ctrl.sv
// Register scoreboard for in-order issue: tracks long-latency destinations,
// detects RAW/WAW hazards against decode, and quiesces the pipe on request.
module scoreboard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  wd,
    input  logic        wb_en,
    input  logic        long_lat,
    input  logic        pipe_adv,
    input  logic        kill,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        drain_req,
    output logic        issue_ok,
    output logic        drain_ack,
    output logic        busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] clr_vec;
    logic [31:0] set_vec;
    logic [31:0] pend_eff;
    logic        hazard;
    logic        run_ok;
    logic        issue;
    logic        stall;

    // Writeback data is forwarded in decode, so its bit is already free.
    assign clr_vec  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign pend_eff = pend_q & ~clr_vec;

    assign hazard = (rs1_used & pend_eff[rs1])
                  | (rs2_used & pend_eff[rs2])
                  | (wb_en    & pend_eff[wd]);

    assign run_ok   = (state_q == RUN) & ~drain_req;
    assign issue_ok = issue_valid & ~hazard & ~kill & run_ok;
    assign issue    = issue_ok & pipe_adv;
    assign stall    = issue_valid & ~kill & pipe_adv & ~issue_ok;

    always_comb begin
        set_vec = 32'd0;
        if (issue && wb_en && long_lat && (wd != 5'd0)) begin
            set_vec = 32'd1 << wd;
        end
    end

    // Set after clear so a same-cycle reissue of the register wins.
    always_comb begin
        pend_d    = (pend_q & ~clr_vec) | set_vec;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)         state_d = RUN;
                else if (pend_q == '0)  state_d = ACK;
            end
            ACK: begin
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pend_q  <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = |pend_q;
    assign drain_ack = (state_q == ACK);
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  rs1, rs2, wd, wb_rd;
    logic        rs1_used, rs2_used, wb_en, long_lat;
    logic        pipe_adv, kill, wb_valid, drain_req;
    logic        issue_ok, drain_ack, busy;
    logic [31:0] stall_cnt;

    typedef struct {
        string       nm;
        logic        ok;
        logic        busy;
        logic        ack;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    scoreboard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .wd          (wd),
        .wb_en       (wb_en),
        .long_lat    (long_lat),
        .pipe_adv    (pipe_adv),
        .kill        (kill),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .drain_req   (drain_req),
        .issue_ok    (issue_ok),
        .drain_ack   (drain_ack),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.nm, "issue_ok", {31'd0, issue_ok}, {31'd0, e.ok});
            cmp(e.nm, "busy", {31'd0, busy}, {31'd0, e.busy});
            cmp(e.nm, "drain_ack", {31'd0, drain_ack}, {31'd0, e.ack});
            cmp(e.nm, "stall_cnt", stall_cnt, e.cnt);
        end
    end

    task automatic drive(
        input string nm,
        input logic iv, input logic [4:0] r1, input logic u1,
        input logic [4:0] r2, input logic u2,
        input logic [4:0] w, input logic we, input logic ll,
        input logic adv, input logic kl,
        input logic wv, input logic [4:0] wr,
        input logic dr, input logic rs,
        input logic eok, input logic eb, input logic ea,
        input logic [31:0] ec);
        exp_t e;
        issue_valid = iv; rs1 = r1; rs1_used = u1;
        rs2 = r2; rs2_used = u2;
        wd = w; wb_en = we; long_lat = ll;
        pipe_adv = adv; kill = kl;
        wb_valid = wv; wb_rd = wr;
        drain_req = dr; rst = rs;
        e.nm = nm; e.ok = eok; e.busy = eb; e.ack = ea; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    task automatic step(
        input string nm,
        input logic iv, input logic [4:0] r1, input logic u1,
        input logic [4:0] r2, input logic u2,
        input logic [4:0] w, input logic we, input logic ll,
        input logic adv, input logic kl,
        input logic wv, input logic [4:0] wr,
        input logic dr, input logic rs,
        input logic eok, input logic eb, input logic ea,
        input logic [31:0] ec);
        @(posedge clk);
        #1;
        drive(nm, iv, r1, u1, r2, u2, w, we, ll, adv, kl,
              wv, wr, dr, rs, eok, eb, ea, ec);
    endtask

    // Load long-latency wd while reading x1.
    task automatic lw(input string nm, input logic [4:0] w,
                      input logic eb, input logic [31:0] ec);
        step(nm, 1, 5'd1, 1, 5'd0, 0, w, 1, 1, 1, 0, 0, 5'd0, 0, 0,
             1, eb, 0, ec);
    endtask

    task automatic idle(input string nm, input logic wv, input logic [4:0] wr,
                        input logic dr, input logic eb, input logic ea,
                        input logic [31:0] ec);
        step(nm, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, wv, wr, dr, 0,
             0, eb, ea, ec);
    endtask

    initial begin
        issue_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
        wd = 0; wb_en = 0; long_lat = 0; pipe_adv = 0; kill = 0;
        wb_valid = 0; wb_rd = 0; drain_req = 0; rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        exp_q.push_back('{nm: "reset", ok: 0, busy: 0, ack: 0, cnt: 0});

        // load-use stall until writeback bypass
        lw("lw_x5", 5'd5, 0, 0);
        step("use1", 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 0);
        step("use2", 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 1);
        step("use_wb", 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 1, 5'd5, 0, 0,
             1, 1, 0, 2);
        idle("after_wb", 0, 5'd0, 0, 0, 0, 2);

        // x0 never pending
        lw("lw_x0", 5'd0, 0, 2);
        step("use_x0", 1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             1, 0, 0, 2);

        // set/clear collision on x7
        lw("lw_x7", 5'd7, 0, 2);
        step("coll", 1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 1, 0, 1, 5'd7, 0, 0,
             1, 1, 0, 2);
        idle("coll_busy", 1, 5'd7, 0, 1, 0, 2);

        // kill suppresses issue, set and stall count
        step("kill", 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 1, 1, 0, 5'd0, 0, 0,
             0, 0, 0, 2);
        idle("kill_after", 0, 5'd0, 0, 0, 0, 2);

        // drain with x3,x4 pending
        lw("lw_x3", 5'd3, 0, 2);
        step("lw_x4", 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 1, 0, 0, 5'd0, 0, 0,
             1, 1, 0, 2);
        step("drn_req", 1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 0, 1, 0, 0, 5'd0, 1, 0,
             0, 1, 0, 2);
        idle("drn_wb3", 1, 5'd3, 1, 1, 0, 3);
        idle("drn_wb4", 1, 5'd4, 1, 1, 0, 3);
        idle("drn_empty", 0, 5'd0, 1, 0, 0, 3);
        idle("ack1", 0, 5'd0, 1, 0, 1, 3);
        idle("ack_hold", 0, 5'd0, 1, 0, 1, 3);
        idle("ack_drop", 0, 5'd0, 0, 0, 1, 3);
        step("run_again", 1, 5'd1, 1, 5'd0, 0, 5'd1, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             1, 0, 0, 3);

        // drain abandoned by dropping request
        lw("lw_x8", 5'd8, 0, 3);
        idle("abrt_req", 0, 5'd0, 1, 1, 0, 3);
        step("abrt_drop", 1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 3);
        step("abrt_run", 1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             1, 1, 0, 4);

        // WAW and rs2 hazards
        step("waw", 1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 4);
        idle("wb_x8", 1, 5'd8, 0, 1, 0, 5);
        idle("empty", 0, 5'd0, 0, 0, 0, 5);
        lw("lw_x12", 5'd12, 0, 5);
        step("rs2_noadv", 1, 5'd1, 1, 5'd12, 1, 5'd13, 1, 0, 0, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 5);
        step("rs2_adv", 1, 5'd1, 1, 5'd12, 1, 5'd13, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 5);
        idle("wb_x12", 1, 5'd12, 0, 1, 0, 6);
        idle("empty2", 0, 5'd0, 0, 0, 0, 6);

        // saturation, then reset in DRAIN
        lw("lw_x14", 5'd14, 0, 6);
        @(posedge clk);
        #1;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        drive("sat0", 1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 1, 0, 0, 5'd0, 0, 0,
              0, 1, 0, 32'hFFFF_FFFE);
        step("sat1", 1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 32'hFFFF_FFFF);
        step("sat2", 1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             0, 1, 0, 32'hFFFF_FFFF);
        step("sat_drn", 1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 1, 0, 0, 5'd0, 1, 0,
             0, 1, 0, 32'hFFFF_FFFF);
        step("rst_drn", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1, 1,
             0, 1, 0, 32'hFFFF_FFFF);
        step("post_rst", 1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 1, 0, 0, 5'd0, 0, 0,
             1, 0, 0, 0);
        idle("post_rst2", 0, 5'd0, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: issue_valid  in  1  decode stage holds a valid instruction.
REQ-004 SHALL have: rs1, rs2  in  5 each  source register indices of the decode-stage instruction.
REQ-005 SHALL have: rs1_used, rs2_used  in  1 each  the corresponding source is read.
REQ-006 SHALL have: wd  in  5  destination index; wb_en  in  1  instruction writes wd.
REQ-007 SHALL have: long_lat  in  1  instruction is a load or multi-cycle mul/div (result not forwardable at issue).
REQ-008 SHALL have: pipe_adv  in  1  global pipeline-advance qualifier (overall proceed).
REQ-009 SHALL have: kill  in  1  decode-stage instruction squashed by a taken jump/branch.
REQ-010 SHALL have: wb_valid  in  1, wb_rd  in  5  long-latency result written back this cycle.
REQ-011 SHALL have: drain_req  in  1  level request to quiesce (fence/CSR access).
REQ-012 SHALL have: issue_ok  out  1  decode instruction may advance this cycle (combinational).
REQ-013 SHALL have: drain_ack  out  1, busy  out  1, stall_cnt  out  32.

Function
REQ-014 SHALL hold a 32-bit pending vector; bit 0 (x0) SHALL read 0 permanently.
REQ-015 Hazard SHALL be: (rs1_used & pend_eff[rs1]) | (rs2_used & pend_eff[rs2]) | (wb_en & pend_eff[wd]) (RAW and WAW).
REQ-016 pend_eff SHALL be pending with bit wb_rd cleared when wb_valid is high (same-cycle writeback bypass, decode forwards wb data).
REQ-017 issue_ok SHALL be issue_valid & ~hazard & ~kill & (state==RUN).
REQ-018 An issue SHALL occur when issue_ok & pipe_adv; on issue with wb_en & long_lat & wd!=0, pending[wd] SHALL set next cycle.
REQ-019 wb_valid SHALL clear pending[wb_rd] next cycle; if an issue sets the same bit in that cycle, set SHALL win.
REQ-020 kill SHALL suppress issue and any pending set that cycle; it SHALL NOT clear existing bits.
REQ-021 busy SHALL equal OR of the pending vector (registered state, not pend_eff).
REQ-022 FSM states: RUN, DRAIN, ACK.
REQ-023 RUN -> DRAIN when drain_req is high; issue is blocked from that same cycle.
REQ-024 DRAIN -> ACK in the cycle after the pending vector becomes all-zero; drain_ack SHALL be 1 only in ACK.
REQ-025 ACK SHALL remain while drain_req is high; ACK -> RUN on drain_req low.
REQ-026 drain_req dropping in DRAIN SHALL return the FSM to RUN next cycle, no ack.
REQ-027 stall_cnt SHALL increment by 1 each cycle with issue_valid & ~kill & pipe_adv & ~issue_ok; it SHALL saturate at 0xFFFF_FFFF.
REQ-028 Latency: pending/state/counter updates are one cycle; issue_ok has zero-cycle latency from inputs.

Reset
REQ-029 With rst high at a clock edge: pending=0, state=RUN, stall_cnt=0; busy=0, drain_ack=0.
REQ-030 Reset SHALL take priority over all simultaneous issue, writeback and drain events.
REQ-031 Reset mid-DRAIN SHALL abandon the drain without asserting drain_ack.

Verification
REQ-032 Load-use: issue lw x5 (long_lat), next cycle add rs1=x5 -> issue_ok=0, stall_cnt +1 per cycle until wb_valid wb_rd=5; issue_ok=1 in that wb cycle.
REQ-033 x0: long-latency issue wd=0, then rs1=0 -> issue_ok=1, busy=0.
REQ-034 Set/clear collision: wb_valid wb_rd=7 same cycle as new lw x7 issue -> pending[7]=1 next cycle, busy=1.
REQ-035 Kill: issue_valid, long_lat, wd=9, kill=1 -> issue_ok=0, pending[9] stays 0, stall_cnt unchanged.
REQ-036 Drain: pending x3,x4; drain_req=1 -> issue_ok=0; wb x3 then x4 -> drain_ack=1 one cycle after vector empty; drain_req=0 -> RUN next cycle.
REQ-037 Saturation/reset: force stall_cnt to 0xFFFF_FFFE, stall 3 cycles -> 0xFFFF_FFFF; assert rst in DRAIN -> state RUN, all outputs reset values.
